// File: rtl/vga_timing_pkg.sv
// =============================================================================
// vga_timing_pkg : 640x480@60 timing constants, sync bundle type, bar helper.
// Revision 1.0
// =============================================================================
`default_nettype none

package vga_timing_pkg;

    localparam int c_DEF_TOTAL_COLS    = 800;
    localparam int c_DEF_TOTAL_ROWS    = 525;
    localparam int c_DEF_ACTIVE_COLS   = 640;
    localparam int c_DEF_ACTIVE_ROWS   = 480;
    localparam int c_DEF_H_FRONT_PORCH = 16;
    localparam int c_DEF_H_SYNC        = 96;
    localparam int c_DEF_V_FRONT_PORCH = 10;
    localparam int c_DEF_V_SYNC        = 2;
    localparam int c_DEF_VIDEO_DELAY   = 2;

    localparam int c_DEF_COL_W = $clog2(c_DEF_TOTAL_COLS);
    localparam int c_DEF_ROW_W = $clog2(c_DEF_TOTAL_ROWS);

    typedef struct packed {
        logic active;
        logic hsync_n;
        logic vsync_n;
    } sync_bundle_t;

    localparam sync_bundle_t c_SYNC_IDLE = '{active: 1'b0, hsync_n: 1'b1, vsync_n: 1'b1};

    // Colour-bar index: 64-pixel-wide bars taken from column bits [8:6].
    function automatic logic [2:0] bar_index(input int unsigned col);
        return 3'((col >> 6) & 32'd7);
    endfunction

endpackage

`default_nettype wire

// File: rtl/vga_delay_line.sv
// =============================================================================
// vga_delay_line : WIDTH x DEPTH shift register with sync reset; DEPTH 0 = wire.
// Revision 1.0
// =============================================================================
`default_nettype none

module vga_delay_line #(
    parameter int               WIDTH     = 1,
    parameter int               DEPTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o
);

    generate
        if (DEPTH == 0) begin : g_passthru
            assign data_o = data_i;
        end else begin : g_shift
            logic [WIDTH-1:0] stage_q [DEPTH];

            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        stage_q[i] <= RESET_VAL;
                    end
                end else begin
                    stage_q[0] <= data_i;
                    for (int i = 1; i < DEPTH; i++) begin
                        stage_q[i] <= stage_q[i-1];
                    end
                end
            end

            assign data_o = stage_q[DEPTH-1];
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/vga_timing_gen.sv
// =============================================================================
// vga_timing_gen : VGA counters, porch/pulse syncs, blanked aligned video out.
// Optional colour bars when VGA_TIMING_TEST_PATTERN_EN is defined. Revision 1.0
// =============================================================================
`default_nettype none

module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int c_TOTAL_COLS    = c_DEF_TOTAL_COLS,
    parameter int c_TOTAL_ROWS    = c_DEF_TOTAL_ROWS,
    parameter int c_ACTIVE_COLS   = c_DEF_ACTIVE_COLS,
    parameter int c_ACTIVE_ROWS   = c_DEF_ACTIVE_ROWS,
    parameter int c_H_FRONT_PORCH = c_DEF_H_FRONT_PORCH,
    parameter int c_H_SYNC        = c_DEF_H_SYNC,
    parameter int c_V_FRONT_PORCH = c_DEF_V_FRONT_PORCH,
    parameter int c_V_SYNC        = c_DEF_V_SYNC,
    parameter int c_VIDEO_DELAY   = c_DEF_VIDEO_DELAY
) (
    input  logic                            i_Clk,
    input  logic                            i_Reset,
`ifdef VGA_TIMING_TEST_PATTERN_EN
    input  logic                            i_Pattern_En,
`endif
    input  logic [3:0]                      i_Red_Video,
    input  logic [3:0]                      i_Grn_Video,
    input  logic [3:0]                      i_Blu_Video,
    output logic [$clog2(c_TOTAL_COLS)-1:0] o_Col_Count,
    output logic [$clog2(c_TOTAL_ROWS)-1:0] o_Row_Count,
    output logic                            o_Frame_Start,
    output logic                            o_HSync,
    output logic                            o_VSync,
    output logic [3:0]                      o_Red_Video,
    output logic [3:0]                      o_Grn_Video,
    output logic [3:0]                      o_Blu_Video
);

    localparam int COL_W = $clog2(c_TOTAL_COLS);
    localparam int ROW_W = $clog2(c_TOTAL_ROWS);

    localparam logic [COL_W-1:0] c_COL_LAST = COL_W'(c_TOTAL_COLS - 1);
    localparam logic [ROW_W-1:0] c_ROW_LAST = ROW_W'(c_TOTAL_ROWS - 1);
    localparam logic [COL_W-1:0] c_ACT_COLS = COL_W'(c_ACTIVE_COLS);
    localparam logic [ROW_W-1:0] c_ACT_ROWS = ROW_W'(c_ACTIVE_ROWS);
    localparam logic [COL_W-1:0] c_HS_FIRST = COL_W'(c_ACTIVE_COLS + c_H_FRONT_PORCH);
    localparam logic [COL_W-1:0] c_HS_LAST  = COL_W'(c_ACTIVE_COLS + c_H_FRONT_PORCH + c_H_SYNC - 1);
    localparam logic [ROW_W-1:0] c_VS_FIRST = ROW_W'(c_ACTIVE_ROWS + c_V_FRONT_PORCH);
    localparam logic [ROW_W-1:0] c_VS_LAST  = ROW_W'(c_ACTIVE_ROWS + c_V_FRONT_PORCH + c_V_SYNC - 1);

    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic             frame_start_q;
    logic             hsync_q, vsync_q;
    logic [3:0]       red_q, grn_q, blu_q;

    sync_bundle_t     w_sync_raw;
    sync_bundle_t     w_sync_dly;
    logic [3:0]       w_red_src, w_grn_src, w_blu_src;

    always_comb begin
        col_d = col_q + COL_W'(1);
        row_d = row_q;
        if (col_q == c_COL_LAST) begin
            col_d = '0;
            row_d = (row_q == c_ROW_LAST) ? '0 : row_q + ROW_W'(1);
        end
    end

    // Reset parks the counters on the last pixel so the first edge lands on (0,0).
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            col_q         <= c_COL_LAST;
            row_q         <= c_ROW_LAST;
            frame_start_q <= 1'b0;
        end else begin
            col_q         <= col_d;
            row_q         <= row_d;
            frame_start_q <= (col_d == '0) && (row_d == '0);
        end
    end

    always_comb begin
        w_sync_raw         = c_SYNC_IDLE;
        w_sync_raw.active  = (col_q < c_ACT_COLS) && (row_q < c_ACT_ROWS);
        w_sync_raw.hsync_n = !((col_q >= c_HS_FIRST) && (col_q <= c_HS_LAST));
        w_sync_raw.vsync_n = !((row_q >= c_VS_FIRST) && (row_q <= c_VS_LAST));
    end

    vga_delay_line #(
        .WIDTH     ($bits(sync_bundle_t)),
        .DEPTH     (c_VIDEO_DELAY),
        .RESET_VAL (c_SYNC_IDLE)
    ) u_sync_dly (
        .clk_i  (i_Clk),
        .rst_i  (i_Reset),
        .data_i (w_sync_raw),
        .data_o (w_sync_dly)
    );

`ifdef VGA_TIMING_TEST_PATTERN_EN
    logic [2:0] w_bar_raw;
    logic [2:0] w_bar_dly;

    assign w_bar_raw = bar_index(32'(col_q));

    vga_delay_line #(
        .WIDTH     (3),
        .DEPTH     (c_VIDEO_DELAY),
        .RESET_VAL (3'b000)
    ) u_bar_dly (
        .clk_i  (i_Clk),
        .rst_i  (i_Reset),
        .data_i (w_bar_raw),
        .data_o (w_bar_dly)
    );

    assign w_red_src = i_Pattern_En ? {4{w_bar_dly[2]}} : i_Red_Video;
    assign w_grn_src = i_Pattern_En ? {4{w_bar_dly[1]}} : i_Grn_Video;
    assign w_blu_src = i_Pattern_En ? {4{w_bar_dly[0]}} : i_Blu_Video;
`else
    assign w_red_src = i_Red_Video;
    assign w_grn_src = i_Grn_Video;
    assign w_blu_src = i_Blu_Video;
`endif

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            hsync_q <= 1'b1;
            vsync_q <= 1'b1;
            red_q   <= 4'h0;
            grn_q   <= 4'h0;
            blu_q   <= 4'h0;
        end else begin
            hsync_q <= w_sync_dly.hsync_n;
            vsync_q <= w_sync_dly.vsync_n;
            red_q   <= w_sync_dly.active ? w_red_src : 4'h0;
            grn_q   <= w_sync_dly.active ? w_grn_src : 4'h0;
            blu_q   <= w_sync_dly.active ? w_blu_src : 4'h0;
        end
    end

    assign o_Col_Count   = col_q;
    assign o_Row_Count   = row_q;
    assign o_Frame_Start = frame_start_q;
    assign o_HSync       = hsync_q;
    assign o_VSync       = vsync_q;
    assign o_Red_Video   = red_q;
    assign o_Grn_Video   = grn_q;
    assign o_Blu_Video   = blu_q;

endmodule

`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
// =============================================================================
// tb_vga_timing_gen : directed checks of vga_timing_gen (default and small frame).
// Revision 1.0
// =============================================================================
`default_nettype none

module tb_vga_timing_gen;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] vid_in = 4'hA;
    logic       pat_en = 1'b1;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    // Default 640x480 instance
    logic [9:0] m_col, m_row;
    logic       m_fs, m_hs, m_vs;
    logic [3:0] m_r, m_g, m_b;

    vga_timing_gen u_dut (
        .i_Clk(clk), .i_Reset(rst),
`ifdef VGA_TIMING_TEST_PATTERN_EN
        .i_Pattern_En(1'b0),
`endif
        .i_Red_Video(vid_in), .i_Grn_Video(vid_in), .i_Blu_Video(vid_in),
        .o_Col_Count(m_col), .o_Row_Count(m_row), .o_Frame_Start(m_fs),
        .o_HSync(m_hs), .o_VSync(m_vs),
        .o_Red_Video(m_r), .o_Grn_Video(m_g), .o_Blu_Video(m_b)
    );

    // Small frame (100x60, active 80x48) so whole frames fit in the run
    logic [6:0] s_col;
    logic [5:0] s_row;
    logic       s_fs, s_hs, s_vs;
    logic [3:0] s_r, s_g, s_b;

    vga_timing_gen #(
        .c_TOTAL_COLS(100), .c_TOTAL_ROWS(60), .c_ACTIVE_COLS(80), .c_ACTIVE_ROWS(48),
        .c_H_FRONT_PORCH(4), .c_H_SYNC(8), .c_V_FRONT_PORCH(3), .c_V_SYNC(2),
        .c_VIDEO_DELAY(2)
    ) u_dut_s (
        .i_Clk(clk), .i_Reset(rst),
`ifdef VGA_TIMING_TEST_PATTERN_EN
        .i_Pattern_En(1'b0),
`endif
        .i_Red_Video(vid_in), .i_Grn_Video(vid_in), .i_Blu_Video(vid_in),
        .o_Col_Count(s_col), .o_Row_Count(s_row), .o_Frame_Start(s_fs),
        .o_HSync(s_hs), .o_VSync(s_vs),
        .o_Red_Video(s_r), .o_Grn_Video(s_g), .o_Blu_Video(s_b)
    );

`ifdef VGA_TIMING_TEST_PATTERN_EN
    logic [9:0] p_col, p_row;
    logic       p_fs, p_hs, p_vs;
    logic [3:0] p_r, p_g, p_b;

    vga_timing_gen #(.c_VIDEO_DELAY(0)) u_dut_p (
        .i_Clk(clk), .i_Reset(rst), .i_Pattern_En(pat_en),
        .i_Red_Video(vid_in), .i_Grn_Video(vid_in), .i_Blu_Video(vid_in),
        .o_Col_Count(p_col), .o_Row_Count(p_row), .o_Frame_Start(p_fs),
        .o_HSync(p_hs), .o_VSync(p_vs),
        .o_Red_Video(p_r), .o_Grn_Video(p_g), .o_Blu_Video(p_b)
    );
`endif

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Expected outputs for the cycle k after reset release; 0xAAA is 4'hA on all channels.
    task automatic expect_out(input int k, input int tc, input int tr, input int ac, input int ar,
                              input int hfp, input int hs, input int vfp, input int vs,
                              input int d, output int hs_n, output int vs_n, output int vid);
        int t, c, r;
        hs_n = 1; vs_n = 1; vid = 0;
        if (k >= d + 1) begin
            t    = (k - d - 1) % (tc * tr);
            c    = t % tc;
            r    = t / tc;
            hs_n = (c >= ac + hfp && c < ac + hfp + hs) ? 0 : 1;
            vs_n = (r >= ar + vfp && r < ar + vfp + vs) ? 0 : 1;
            vid  = (c < ac && r < ar) ? 'hAAA : 0;
        end
    endtask

    task automatic check_main(input int k, input string pfx);
        int eh, ev, evid;
        expect_out(k, 800, 525, 640, 480, 16, 96, 10, 2, 2, eh, ev, evid);
        check_eq({pfx, "m_col"}, int'(m_col), k % 800);
        check_eq({pfx, "m_row"}, int'(m_row), (k / 800) % 525);
        check_eq({pfx, "m_fs"}, int'(m_fs), (k % 420000 == 0) ? 1 : 0);
        check_eq({pfx, "m_hsync"}, int'(m_hs), eh);
        check_eq({pfx, "m_vsync"}, int'(m_vs), ev);
        check_eq({pfx, "m_video"}, int'({m_r, m_g, m_b}), evid);
    endtask

    task automatic check_small(input int k);
        int eh, ev, evid;
        expect_out(k, 100, 60, 80, 48, 4, 8, 3, 2, 2, eh, ev, evid);
        check_eq("s_col", int'(s_col), k % 100);
        check_eq("s_row", int'(s_row), (k / 100) % 60);
        check_eq("s_fs", int'(s_fs), (k % 6000 == 0) ? 1 : 0);
        check_eq("s_hsync", int'(s_hs), eh);
        check_eq("s_vsync", int'(s_vs), ev);
        check_eq("s_video", int'({s_r, s_g, s_b}), evid);
    endtask

    initial begin
        int k;
        int h_fall0, h_fall1, h_rise0, v_fall0, v_rise0, fs_cnt, guard;
        logic prev_mh, prev_sv;
        h_fall0 = -1; h_fall1 = -1; h_rise0 = -1; v_fall0 = -1; v_rise0 = -1; fs_cnt = 0;

        repeat (5) @(posedge clk);
        @(negedge clk);
        check_eq("rst_col", int'(m_col), 799);
        check_eq("rst_row", int'(m_row), 524);
        check_eq("rst_fs", int'(m_fs), 0);
        check_eq("rst_sync", int'({m_hs, m_vs}), 3);
        check_eq("rst_video", int'({m_r, m_g, m_b}), 0);
        check_eq("rst_s_cnt", int'({s_col, s_row}), (99 << 6) | 59);
        rst = 1'b0;
        prev_mh = 1'b1; prev_sv = 1'b1;

        for (k = 0; k < 12100; k++) begin
            @(negedge clk);
            check_main(k, "");
            check_small(k);
            if (prev_mh && !m_hs) begin
                if (h_fall0 < 0) h_fall0 = k;
                else if (h_fall1 < 0) h_fall1 = k;
            end
            if (!prev_mh && m_hs && h_rise0 < 0) h_rise0 = k;
            if (prev_sv && !s_vs && v_fall0 < 0) v_fall0 = k;
            if (!prev_sv && s_vs && v_rise0 < 0) v_rise0 = k;
            if (s_fs) fs_cnt++;
            prev_mh = m_hs; prev_sv = s_vs;
`ifdef VGA_TIMING_TEST_PATTERN_EN
            if (k <= 800) begin
                int c, idx, e;
                c   = k - 1;
                idx = c / 64;
                e   = (k >= 1 && c < 640) ? (((idx >> 2) & 1) * 'hF00 + ((idx >> 1) & 1) * 'h0F0 + (idx & 1) * 'h00F) : 0;
                check_eq("p_video", int'({p_r, p_g, p_b}), e);
                check_eq("p_hsync", int'(p_hs), (k >= 1 && c >= 656 && c <= 751) ? 0 : 1);
            end
`endif
        end

        check_eq("h_fall_first", h_fall0, 659);
        check_eq("h_low_width", h_rise0 - h_fall0, 96);
        check_eq("h_line_period", h_fall1 - h_fall0, 800);
        check_eq("s_v_fall", v_fall0, 5103);
        check_eq("s_v_low_width", v_rise0 - v_fall0, 200);
        check_eq("s_fs_pulses", fs_cnt, 3);

        // Mid-line reset while HSync is low
        guard = 0;
        while (m_col != 10'd700 && guard < 900) begin
            @(negedge clk);
            guard++;
        end
        check_eq("wait_col700", int'(m_col), 700);
        check_eq("pre_rst_hsync", int'(m_hs), 0);
        rst = 1'b1;
        @(negedge clk);
        check_eq("mid_rst_hsync", int'(m_hs), 1);
        check_eq("mid_rst_video", int'({m_r, m_g, m_b}), 0);
        check_eq("mid_rst_col", int'(m_col), 799);
        check_eq("mid_rst_row", int'(m_row), 524);
        rst = 1'b0;
        for (k = 0; k < 6; k++) begin
            @(negedge clk);
            check_main(k, "post_");
            check_small(k);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/vga_timing_gen.md
# vga_timing_gen

VGA timing source at the head of the video chain. Free-running column/row counters generate standard porch-and-pulse HSync/VSync and publish the raw counts to downstream pixel logic (game/draw blocks). It accepts the colour those blocks compute with known latency, blanks it outside the active area and emits syncs and video on the same cycle.

## Interface
Parameters:
- c_TOTAL_COLS, 800: pixels per line.
- c_TOTAL_ROWS, 525: lines per frame.
- c_ACTIVE_COLS, 640: visible pixels per line.
- c_ACTIVE_ROWS, 480: visible lines.
- c_H_FRONT_PORCH, 16: pixels between active end and HSync start.
- c_H_SYNC, 96: HSync pulse width; back porch is the remainder.
- c_V_FRONT_PORCH, 10: lines between active end and VSync start.
- c_V_SYNC, 2: VSync pulse width in lines.
- c_VIDEO_DELAY, 2: latency (0..8) from counts to i_*_Video.

Ports:
- Clock and reset: one clock, i_Clk; reset i_Reset is synchronous and active-high.
- i_Clk, in, 1: pixel clock.
- i_Reset, in, 1: synchronous, active-high reset.
- i_Red_Video, i_Grn_Video, i_Blu_Video, in, 4 each: colour for the counts issued c_VIDEO_DELAY cycles earlier.
- o_Col_Count, out, $clog2(c_TOTAL_COLS): current column.
- o_Row_Count, out, $clog2(c_TOTAL_ROWS): current row.
- o_Frame_Start, out, 1: high for the one cycle in which counts are (0,0).
- o_HSync, o_VSync, out, 1: active-low sync pulses, aligned with video out.
- o_Red_Video, o_Grn_Video, o_Blu_Video, out, 4 each: blanked, aligned video.

## Operation
- Column counter increments every cycle and wraps from c_TOTAL_COLS-1 to 0. The row counter increments on each column wrap and wraps from c_TOTAL_ROWS-1 to 0.
- Decoding is combinational from the counters:
  - active = col < c_ACTIVE_COLS && row < c_ACTIVE_ROWS.
  - hsync_n = 0 iff col is in [c_ACTIVE_COLS+c_H_FRONT_PORCH, c_ACTIVE_COLS+c_H_FRONT_PORCH+c_H_SYNC-1]. With defaults this is 656..751.
  - vsync_n = 0 iff row is in [c_ACTIVE_ROWS+c_V_FRONT_PORCH, +c_V_SYNC-1]. With defaults this is 490..491. VSync is asserted for whole lines, including the porch columns.
- active, hsync_n and vsync_n pass through a c_VIDEO_DELAY-stage shift line, then an output register.
- Video output register loads o_*_Video <= active_d ? i_*_Video : 4'h0.
- Reset values:
  - o_Col_Count = c_TOTAL_COLS-1, o_Row_Count = c_TOTAL_ROWS-1.
  - o_Frame_Start = 0, o_HSync = o_VSync = 1, video = 0.
  - All delay stages reset to active=0, sync=1.
- Reset asserted mid-frame takes effect on the next edge and discards in-flight pipeline contents; no partial pulse survives.

## Timing
- The first edge after reset release moves the counters to (0,0) and asserts o_Frame_Start for exactly one cycle. It re-asserts every c_TOTAL_COLS*c_TOTAL_ROWS cycles (420000 with defaults).
- Counts and o_Frame_Start have zero latency: they are the counter registers.
- Latency from a count value to its o_HSync, o_VSync and o_*_Video is c_VIDEO_DELAY+1 cycles.
- c_VIDEO_DELAY=0 means no shift stages: output register only.
- Line period is c_TOTAL_COLS cycles. HSync low for c_H_SYNC cycles per line, VSync low for c_V_SYNC*c_TOTAL_COLS cycles per frame.

## Configuration
- VGA_TIMING_TEST_PATTERN_EN defined:
  - Adds input i_Pattern_En (1 bit).
  - While i_Pattern_En is high, i_*_Video is replaced before blanking by vertical colour bars.
  - Bar index is delayed column bits [8:6], so the pattern is aligned with the syncs. Red = index[2], Grn = index[1], Blu = index[0]; each channel is 4'hF or 4'h0.
  - The column is delayed alongside the sync line.
- Not defined: port absent, no column delay stages, video passes through only blanking.

## Structure
- Package vga_timing_pkg holds:
  - The 640x480@60 constants (totals, actives, porches, sync widths).
  - The default c_VIDEO_DELAY.
  - Width localparams derived via $clog2.
- Sub-module vga_delay_line: parametric width × depth shift register with synchronous reset value, depth 0 is a wire. It is instantiated for the {active, hsync_n, vsync_n} bundle and, when the pattern is enabled, for the column.

## Test plan
- Reset held 5 cycles, then released: counts 799/524 during reset. First post-reset cycle gives counts 0/0 with o_Frame_Start=1; next cycle gives 1/0 with o_Frame_Start=0.
- Run one line with defaults (delay 2): o_HSync falls exactly 659 cycles after the (0,0) cycle (656+3), stays low 96 cycles, and the line period is 800.
- Run one frame: o_VSync low 1600 consecutive cycles beginning 490*800+3 cycles after frame start. o_Frame_Start pulses exactly once per 420000 cycles.
- Drive i_*_Video=4'hA constantly: output is 4'hA for cols 0..639 of rows 0..479 (shifted 3 cycles) and 4'h0 elsewhere, including row 480 and col 640.
- Assert reset while o_HSync is low at col 700: o_HSync=1 and video=0 on the next edge. The counters restart at (0,0) one cycle after release.
- With the macro defined, i_Pattern_En=1 and c_VIDEO_DELAY=0: cols 0..63 output 0/0/0, 64..127 give Blu=4'hF only, 448..511 give Red=Grn=Blu=4'hF, and every bar edge is aligned with the delayed column.
